// File: rtl/mz_pkg.sv
// -----------------------------------------------------------------------------
// mz_pkg: shared types and helpers for the Mach-Zehnder pulse scheduler.
//   - mz_state_e : 4-bit FSM state encoding, visible on the scheduler's state port
//   - CNT_W_DEF  : default width of the duration fields and the timer
//   - mz_cfg_t   : shadow copy of the configuration, latched when a start is accepted
// The duration fields in mz_cfg_t are CFG_W_MAX bits wide so that one struct
// type serves every CNT_W up to CFG_W_MAX. Narrower values are zero-extended.
// -----------------------------------------------------------------------------
package mz_pkg;

    localparam int CNT_W_DEF = 17;
    localparam int CFG_W_MAX = 32;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_PRE   = 4'd1,
        ST_PI2_A = 4'd2,
        ST_GAP1  = 4'd3,
        ST_PI    = 4'd4,
        ST_GAP2  = 4'd5,
        ST_PI2_B = 4'd6,
        ST_DEAD  = 4'd7,
        ST_DONE  = 4'd8
    } mz_state_e;

    typedef struct packed {
        logic [CFG_W_MAX-1:0] pre;
        logic [CFG_W_MAX-1:0] pi2;
        logic [CFG_W_MAX-1:0] pi;
        logic [CFG_W_MAX-1:0] t;
        logic [CFG_W_MAX-1:0] dead;
        logic [7:0]           rpt;
    } mz_cfg_t;

    // Length in cycles of a timed state; 0 for states that are not timed.
    function automatic logic [CFG_W_MAX-1:0] mz_state_len(input mz_state_e st,
                                                         input mz_cfg_t   cfg);
        logic [CFG_W_MAX-1:0] len;
        case (st)
            ST_PRE:             len = cfg.pre;
            ST_PI2_A, ST_PI2_B: len = cfg.pi2;
            ST_GAP1, ST_GAP2:   len = cfg.t;
            ST_PI:              len = cfg.pi;
            ST_DEAD:            len = cfg.dead;
            default:            len = '0;
        endcase
        return len;
    endfunction

    // First state of a shot: PRE, or PI2_A directly when the pre-delay is 0.
    function automatic mz_state_e mz_shot_entry(input mz_cfg_t cfg);
        return (cfg.pre != '0) ? ST_PRE : ST_PI2_A;
    endfunction

    // States during which the RF gate is open.
    function automatic logic mz_rf_state(input mz_state_e st);
        return (st == ST_PI2_A) || (st == ST_PI) || (st == ST_PI2_B);
    endfunction

endpackage

// File: rtl/mz_pulse_timer.sv
// -----------------------------------------------------------------------------
// mz_pulse_timer: loadable down-counter with a zero flag.
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset (counter to 0)
//   load_i     : load load_val_i this cycle (has priority over counting)
//   load_val_i : value to load (state length minus one)
//   zero_o     : counter is 0; the owning state exits on this cycle
// The counter holds at 0 rather than wrapping.
// -----------------------------------------------------------------------------
module mz_pulse_timer #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/mz_pulse_scheduler.sv
// -----------------------------------------------------------------------------
// mz_pulse_scheduler: Mach-Zehnder pulse sequencer
//   PRE -> PI2_A -> GAP1 -> PI -> GAP2 -> PI2_B -> DONE
// Build option: define SHOT_REPEAT_EN to run cfg_repeat additional shots,
// each preceded by a DEAD interval of cfg_dead cycles. Without it, cfg_repeat
// and cfg_dead are ignored and one shot runs per start.
//
// Ports
//   clk, rst_n        : clock and synchronous active-low reset
//   trig              : start request, looked at only in IDLE
//   abort             : cancel the running sequence (wins over trig in IDLE)
//   cfg_pre/pi2/pi/t  : pre-delay, pi/2 length, pi length, interval T (cycles)
//   cfg_repeat        : additional shots (SHOT_REPEAT_EN builds)
//   cfg_dead          : inter-shot dead time (SHOT_REPEAT_EN builds)
//   rf                : RF gate, registered, high in PI2_A / PI / PI2_B
//   busy              : sequence in progress (not IDLE, not DONE)
//   done              : one-cycle pulse, the DONE state
//   cfg_err           : one-cycle pulse after a start with zero pi/2 or pi
//   state             : current FSM state (mz_state_e encoding)
//   shot_cnt          : completed shots in the current sequence, saturating
// CNT_W must lie in 1..32 (width of the shadow struct fields).
// -----------------------------------------------------------------------------
module mz_pulse_scheduler
    import mz_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trig,
    input  logic             abort,
    input  logic [CNT_W-1:0] cfg_pre,
    input  logic [CNT_W-1:0] cfg_pi2,
    input  logic [CNT_W-1:0] cfg_pi,
    input  logic [CNT_W-1:0] cfg_t,
    input  logic [7:0]       cfg_repeat,
    input  logic [CNT_W-1:0] cfg_dead,
    output logic             rf,
    output logic             busy,
    output logic             done,
    output logic             cfg_err,
    output logic [3:0]       state,
    output logic [7:0]       shot_cnt
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mz_state_e            state_q;
    mz_state_e            state_d;
    mz_cfg_t              shadow_q;
    mz_cfg_t              cfg_in;
    mz_cfg_t              cfg_cur;
    logic [7:0]           shot_cnt_q;
    logic [7:0]           shot_cnt_d;
    logic                 rf_q;
    logic                 rf_d;
    logic                 cfg_err_q;
    logic                 accept;
    logic                 reject;
    logic                 shot_end;
    logic                 tmr_zero;
    logic                 tmr_load;
    logic [CNT_W-1:0]     tmr_load_val;
    logic [CFG_W_MAX-1:0] len_next;
    logic                 unused_cfg_bits;

    // Configuration as presented on the ports, zero-extended to struct width.
    always_comb begin
        cfg_in      = '0;
        cfg_in.pre  = CFG_W_MAX'(cfg_pre);
        cfg_in.pi2  = CFG_W_MAX'(cfg_pi2);
        cfg_in.pi   = CFG_W_MAX'(cfg_pi);
        cfg_in.t    = CFG_W_MAX'(cfg_t);
        cfg_in.dead = CFG_W_MAX'(cfg_dead);
        cfg_in.rpt  = cfg_repeat;
    end

    // In IDLE the decision (and the first timer load) must use the live ports,
    // since the shadow copy is only written by the accepting edge.
    assign cfg_cur = (state_q == ST_IDLE) ? cfg_in : shadow_q;

    // Upper field bits and, without SHOT_REPEAT_EN, the repeat fields are unread.
    assign unused_cfg_bits = ^cfg_cur;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        reject   = 1'b0;
        shot_end = 1'b0;
        if (state_q == ST_IDLE) begin
            if (trig && !abort) begin
                if ((cfg_pi2 != '0) && (cfg_pi != '0)) begin
                    accept  = 1'b1;
                    state_d = mz_shot_entry(cfg_in);
                end else begin
                    reject = 1'b1;
                end
            end
        end else if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_PRE: if (tmr_zero) state_d = ST_PI2_A;
                ST_PI2_A: if (tmr_zero) state_d = (cfg_cur.t != '0) ? ST_GAP1 : ST_PI;
                ST_GAP1: if (tmr_zero) state_d = ST_PI;
                ST_PI: if (tmr_zero) state_d = (cfg_cur.t != '0) ? ST_GAP2 : ST_PI2_B;
                ST_GAP2: if (tmr_zero) state_d = ST_PI2_B;
                ST_PI2_B: begin
                    if (tmr_zero) begin
                        shot_end = 1'b1;
`ifdef SHOT_REPEAT_EN
                        // shot_cnt_q still counts shots before this one, which
                        // equals the number of extra shots completed so far.
                        if (shot_cnt_q < cfg_cur.rpt) begin
                            state_d = (cfg_cur.dead != '0) ? ST_DEAD : mz_shot_entry(cfg_cur);
                        end else begin
                            state_d = ST_DONE;
                        end
`else
                        state_d = ST_DONE;
`endif
                    end
                end
                ST_DEAD: if (tmr_zero) state_d = mz_shot_entry(cfg_cur);
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done = (state_q == ST_DONE);
        rf_d = mz_rf_state(state_d);
    end

    // ---------------- timer ----------------
    // Load length-1 on every state change; untimed states load 0.
    assign len_next     = mz_state_len(state_d, cfg_cur);
    assign tmr_load     = (state_d != state_q);
    assign tmr_load_val = (len_next == '0) ? '0 : (len_next[CNT_W-1:0] - ONE);

    mz_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .zero_o     (tmr_zero)
    );

    // ---------------- datapath registers ----------------
    always_comb begin
        shot_cnt_d = shot_cnt_q;
        if ((state_q != ST_IDLE) && abort) begin
            shot_cnt_d = '0;
        end else if (accept) begin
            shot_cnt_d = '0;
        end else if (shot_end && (shot_cnt_q != 8'hFF)) begin
            shot_cnt_d = shot_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_q   <= '0;
            shot_cnt_q <= '0;
            rf_q       <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            if (accept) begin
                shadow_q <= cfg_in;
            end
            shot_cnt_q <= shot_cnt_d;
            rf_q       <= rf_d;
            cfg_err_q  <= reject;
        end
    end

    assign rf       = rf_q;
    assign cfg_err  = cfg_err_q;
    assign state    = state_q;
    assign shot_cnt = shot_cnt_q;

endmodule
